// File: rtl/writeback_unit.sv
// Writeback stage: collects an execute result or a load response, commits it to the
// register file with a valid/acknowledge handshake and counts retired instructions.
module writeback_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exu_valid,
    output logic             exu_ready,
    input  logic [WIDTH-1:0] exu_result,
    input  logic [4:0]       exu_rd,
    input  logic             exu_rf_we,
    input  logic             exu_is_load,
    input  logic [2:0]       exu_funct3,
    input  logic [1:0]       exu_addr_lo,
    input  logic             lsu_rvalid,
    output logic             lsu_rready,
    input  logic [WIDTH-1:0] lsu_rdata,
    input  logic             lsu_err,
    output logic             rf_we,
    output logic             rf_valid,
    output logic [4:0]       rf_rd_addr,
    output logic [WIDTH-1:0] rf_rd_data,
    input  logic             rf_start,
    output logic             commit_done,
    output logic             wb_fault,
    output logic [63:0]      instret
);

    typedef enum logic [1:0] {StIdle, StWaitMem, StCommit, StWaitAck} state_e;

    state_e           state_q, state_d;
    logic [4:0]       rd_q, rd_d;
    logic             we_q, we_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [1:0]       addr_lo_q, addr_lo_d;
    logic             is_load_q, is_load_d;
    logic             fault_q, fault_d;
    logic             wb_fault_q, wb_fault_d;
    logic             commit_done_q, commit_done_d;
    logic [63:0]      instret_q, instret_d;

    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [WIDTH-1:0] ld_data;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (exu_valid) begin
                    state_d = exu_is_load ? StWaitMem : StCommit;
                end
            end
            StWaitMem: begin
                if (lsu_rvalid) begin
                    state_d = StCommit;
                end
            end
            StCommit: state_d = StWaitAck;
            StWaitAck: begin
                if (rf_start) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs; exu_ready is gated by rst so it reads 0 while reset is held
    always_comb begin
        exu_ready  = 1'b0;
        lsu_rready = 1'b0;
        rf_valid   = 1'b0;
        rf_we      = 1'b0;
        unique case (state_q)
            StIdle:    exu_ready = rst;
            StWaitMem: lsu_rready = 1'b1;
            StCommit: begin
                rf_valid = 1'b1;
                rf_we    = we_q;
            end
            default: ;
        endcase
    end

    // Load lane selection and extension
    always_comb begin
        unique case (addr_lo_q)
            2'd0:    ld_byte = lsu_rdata[7:0];
            2'd1:    ld_byte = lsu_rdata[15:8];
            2'd2:    ld_byte = lsu_rdata[23:16];
            default: ld_byte = lsu_rdata[31:24];
        endcase
        ld_half = addr_lo_q[1] ? lsu_rdata[31:16] : lsu_rdata[15:0];
        case (funct3_q)
            3'b000:  ld_data = {{(WIDTH-8){ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{(WIDTH-16){ld_half[15]}}, ld_half};
            3'b100:  ld_data = {{(WIDTH-8){1'b0}}, ld_byte};
            3'b101:  ld_data = {{(WIDTH-16){1'b0}}, ld_half};
            default: ld_data = lsu_rdata;
        endcase
    end

    always_comb begin
        rd_d          = rd_q;
        we_d          = we_q;
        result_d      = result_q;
        funct3_d      = funct3_q;
        addr_lo_d     = addr_lo_q;
        is_load_d     = is_load_q;
        fault_d       = fault_q;
        wb_fault_d    = 1'b0;
        commit_done_d = 1'b0;
        instret_d     = instret_q;
        unique case (state_q)
            StIdle: begin
                if (exu_valid) begin
                    rd_d      = exu_rd;
                    we_d      = exu_rf_we;
                    result_d  = exu_result;
                    funct3_d  = exu_funct3;
                    addr_lo_d = exu_addr_lo;
                    is_load_d = exu_is_load;
                    fault_d   = 1'b0;
                end
            end
            StWaitMem: begin
                if (lsu_rvalid) begin
                    if (lsu_err) begin
                        we_d       = 1'b0;
                        fault_d    = 1'b1;
                        wb_fault_d = 1'b1;
                    end else if (is_load_q) begin
                        result_d = ld_data;
                    end
                end
            end
            StWaitAck: begin
                if (rf_start) begin
                    commit_done_d = 1'b1;
                    // Faulted loads commit to release fetch but do not retire
                    if (!fault_q) begin
                        instret_d = instret_q + 64'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q          <= '0;
            we_q          <= 1'b0;
            result_q      <= '0;
            funct3_q      <= '0;
            addr_lo_q     <= '0;
            is_load_q     <= 1'b0;
            fault_q       <= 1'b0;
            wb_fault_q    <= 1'b0;
            commit_done_q <= 1'b0;
            instret_q     <= '0;
        end else begin
            rd_q          <= rd_d;
            we_q          <= we_d;
            result_q      <= result_d;
            funct3_q      <= funct3_d;
            addr_lo_q     <= addr_lo_d;
            is_load_q     <= is_load_d;
            fault_q       <= fault_d;
            wb_fault_q    <= wb_fault_d;
            commit_done_q <= commit_done_d;
            instret_q     <= instret_d;
        end
    end

    assign rf_rd_addr  = rd_q;
    assign rf_rd_data  = result_q;
    assign commit_done = commit_done_q;
    assign wb_fault    = wb_fault_q;
    assign instret     = instret_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: directed cases plus randomized loads/ALU results
// checked against a behavioural load-extraction and retirement model.
module tb_writeback_unit;

    logic        clk;
    logic        rst;
    logic        exu_valid;
    logic        exu_ready;
    logic [31:0] exu_result;
    logic [4:0]  exu_rd;
    logic        exu_rf_we;
    logic        exu_is_load;
    logic [2:0]  exu_funct3;
    logic [1:0]  exu_addr_lo;
    logic        lsu_rvalid;
    logic        lsu_rready;
    logic [31:0] lsu_rdata;
    logic        lsu_err;
    logic        rf_we;
    logic        rf_valid;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_rd_data;
    logic        rf_start;
    logic        commit_done;
    logic        wb_fault;
    logic [63:0] instret;

    typedef struct {
        logic [4:0]  rd;
        logic        we;
        logic [31:0] data;
        logic        fault;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [63:0] model_instret = '0;
    logic        ack_en = 1'b1;
    logic        ack_force = 1'b0;
    logic        ack_q;

    writeback_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .exu_valid  (exu_valid),
        .exu_ready  (exu_ready),
        .exu_result (exu_result),
        .exu_rd     (exu_rd),
        .exu_rf_we  (exu_rf_we),
        .exu_is_load(exu_is_load),
        .exu_funct3 (exu_funct3),
        .exu_addr_lo(exu_addr_lo),
        .lsu_rvalid (lsu_rvalid),
        .lsu_rready (lsu_rready),
        .lsu_rdata  (lsu_rdata),
        .lsu_err    (lsu_err),
        .rf_we      (rf_we),
        .rf_valid   (rf_valid),
        .rf_rd_addr (rf_rd_addr),
        .rf_rd_data (rf_rd_data),
        .rf_start   (rf_start),
        .commit_done(commit_done),
        .wb_fault   (wb_fault),
        .instret    (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file model: acknowledges the cycle after rf_valid
    always @(posedge clk or negedge rst) begin
        if (!rst) ack_q <= 1'b0;
        else      ack_q <= rf_valid & ack_en;
    end
    assign rf_start = ack_q | ack_force;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Load result derived from the size/sign rules with plain arithmetic
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] a,
                                               input logic [31:0] w);
        int unsigned b;
        int unsigned h;
        int unsigned sh_b;
        int unsigned sh_h;
        sh_b = 8 * int'(a);
        sh_h = 16 * (int'(a) / 2);
        b = (w >> sh_b) & 32'hFF;
        h = (w >> sh_h) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 128) ? b - 256 : b;
            3'b001:  return (h >= 32768) ? h - 65536 : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    // Monitor: compares every commit against the scoreboard head
    always @(negedge clk) begin
        if (rst) begin
            if (rf_valid) begin
                if (sb.size() == 0) begin
                    chk("rf_valid_unexpected", 64'(rf_valid), 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("rf_rd_addr", 64'(rf_rd_addr), 64'(mon_e.rd));
                    chk("rf_we", 64'(rf_we), 64'(mon_e.we));
                    chk("rf_rd_data", 64'(rf_rd_data), 64'(mon_e.data));
                    chk("wb_fault_at_commit", 64'(wb_fault), 64'(mon_e.fault));
                end
            end else begin
                chk("rf_we_idle", 64'(rf_we), 64'd0);
                chk("wb_fault_idle", 64'(wb_fault), 64'd0);
            end
        end
    end

    task automatic drive_accept(input logic ld, input logic [31:0] res, input logic [4:0] rd,
                                input logic we, input logic [2:0] f3, input logic [1:0] a,
                                input logic [31:0] word, input logic err, output bit acc);
        exp_t e;
        int   n;
        e.rd    = rd;
        e.fault = ld && err;
        e.we    = we && !e.fault;
        e.data  = (ld && !err) ? model_load(f3, a, word) : res;
        exu_valid   = 1'b1;
        exu_result  = res;
        exu_rd      = rd;
        exu_rf_we   = we;
        exu_is_load = ld;
        exu_funct3  = f3;
        exu_addr_lo = a;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 20) begin
            @(negedge clk);
            acc = exu_ready;
            @(posedge clk);
            #1;
            n++;
        end
        chk("exu_accept", 64'(acc), 64'd1);
        exu_valid = 1'b0;
        if (acc) sb.push_back(e);
    endtask

    task automatic issue(input logic ld, input logic [31:0] res, input logic [4:0] rd,
                         input logic we, input logic [2:0] f3, input logic [1:0] a,
                         input logic [31:0] word, input logic err, input int dly,
                         input logic bp);
        bit acc;
        int n;
        drive_accept(ld, res, rd, we, f3, a, word, err, acc);
        if (!acc) return;
        if (ld) begin
            for (int i = 0; i < dly; i++) begin
                if (bp) begin
                    exu_valid   = 1'b1;
                    exu_rd      = 5'd31;
                    exu_result  = $urandom;
                    exu_rf_we   = 1'b1;
                    exu_is_load = 1'b0;
                end
                @(negedge clk);
                chk("wait_exu_ready", 64'(exu_ready), 64'd0);
                chk("wait_lsu_rready", 64'(lsu_rready), 64'd1);
                @(posedge clk);
                #1;
            end
            exu_valid  = 1'b0;
            lsu_rvalid = 1'b1;
            lsu_rdata  = word;
            lsu_err    = err;
            @(negedge clk);
            chk("resp_lsu_rready", 64'(lsu_rready), 64'd1);
            @(posedge clk);
            #1;
            lsu_rvalid = 1'b0;
            lsu_err    = 1'b0;
            lsu_rdata  = $urandom;
        end
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 20) begin
            @(negedge clk);
            acc = commit_done;
            n++;
        end
        chk("commit_done", 64'(acc), 64'd1);
        if (!(ld && err)) model_instret = model_instret + 64'd1;
        chk("instret", instret, model_instret);
        chk("done_lsu_rready", 64'(lsu_rready), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("commit_done_pulse", 64'(commit_done), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit acc;
        rst = 1'b0;
        exu_valid = 1'b0; exu_result = '0; exu_rd = '0; exu_rf_we = 1'b0;
        exu_is_load = 1'b0; exu_funct3 = '0; exu_addr_lo = '0;
        lsu_rvalid = 1'b0; lsu_rdata = '0; lsu_err = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_exu_ready", 64'(exu_ready), 64'd0);
        chk("rst_rf_valid", 64'(rf_valid), 64'd0);
        chk("rst_instret", instret, 64'd0);
        chk("rst_rf_rd_data", 64'(rf_rd_data), 64'd0);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("exu_ready_after_rst", 64'(exu_ready), 64'd1);

        issue(1'b0, 32'h12345678, 5'd5, 1'b1, 3'b000, 2'd0, '0, 1'b0, 0, 1'b0);
        issue(1'b1, 32'h0BAD0BAD, 5'd7, 1'b1, 3'b000, 2'd3, 32'h80FF_0000, 1'b0, 1, 1'b0);
        issue(1'b1, 32'h0BAD0BAD, 5'd8, 1'b1, 3'b101, 2'd2, 32'h80FF_0000, 1'b0, 0, 1'b0);
        issue(1'b1, 32'hDEADBEEF, 5'd9, 1'b1, 3'b010, 2'd0, 32'h11112222, 1'b1, 2, 1'b0);
        issue(1'b1, 32'h0, 5'd10, 1'b1, 3'b010, 2'd1, 32'hCAFEF00D, 1'b0, 10, 1'b1);
        issue(1'b0, 32'h0000A5A5, 5'd0, 1'b1, 3'b000, 2'd0, '0, 1'b0, 0, 1'b0);
        issue(1'b1, 32'h0, 5'd11, 1'b1, 3'b001, 2'd3, 32'h8001_7FFE, 1'b0, 0, 1'b0);
        issue(1'b1, 32'h0, 5'd12, 1'b1, 3'b100, 2'd1, 32'h0000_9F00, 1'b0, 0, 1'b0);
        issue(1'b1, 32'h0, 5'd13, 1'b0, 3'b111, 2'd2, 32'h7654_3210, 1'b0, 3, 1'b0);

        // Reset while waiting for the register-file acknowledge
        ack_en = 1'b0;
        drive_accept(1'b0, 32'h55AA55AA, 5'd3, 1'b1, 3'b000, 2'd0, '0, 1'b0, acc);
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_async_exu_ready", 64'(exu_ready), 64'd0);
        chk("rst_async_lsu_rready", 64'(lsu_rready), 64'd0);
        chk("rst_async_rf_valid", 64'(rf_valid), 64'd0);
        chk("rst_async_rf_we", 64'(rf_we), 64'd0);
        chk("rst_async_rf_rd_addr", 64'(rf_rd_addr), 64'd0);
        chk("rst_async_rf_rd_data", 64'(rf_rd_data), 64'd0);
        chk("rst_async_commit_done", 64'(commit_done), 64'd0);
        chk("rst_async_wb_fault", 64'(wb_fault), 64'd0);
        chk("rst_async_instret", instret, 64'd0);
        model_instret = '0;
        @(negedge clk);
        #1 rst = 1'b1;
        ack_force = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_commit_done", 64'(commit_done), 64'd0);
            chk("post_rst_exu_ready", 64'(exu_ready), 64'd1);
            chk("post_rst_instret", instret, 64'd0);
        end
        ack_force = 1'b0;
        ack_en    = 1'b1;
        @(posedge clk);
        #1;
        chk("sb_empty_after_rst", 64'(sb.size()), 64'd0);

        // Counter wrap from all-ones
        force dut.instret_q = '1;
        #1 release dut.instret_q;
        model_instret = '1;
        chk("instret_preload", instret, model_instret);
        issue(1'b0, 32'h00000001, 5'd1, 1'b1, 3'b000, 2'd0, '0, 1'b0, 0, 1'b0);
        chk("instret_wrapped", instret, 64'd0);

        for (int k = 0; k < 40; k++) begin
            issue(1'($urandom_range(0, 1)), $urandom, 5'($urandom), 1'($urandom),
                  3'($urandom_range(0, 7)), 2'($urandom), $urandom,
                  1'($urandom_range(0, 7) == 0), int'($urandom_range(0, 4)),
                  1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        chk("sb_empty_end", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
